uart_tx: RTL

UART 8N1 transmitter; the transmit-side counterpart of the team's UART receiver, using the same CLOCK_FREQ/BAUD_RATE timing model.
- Accepts one byte per valid/ready handshake from a local producer.
- Serializes each byte as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Idle line is high; the output is registered and drives the board TX pin directly.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and bit-time helper.
// Used by the transmitter and the receiver state decode.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per symbol; integer division truncates.
  function automatic int calc_bit_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Symbol timer: counts 0..BIT_TIME-1 while enabled, clears when disabled.
// symbol_pre flags the cycle before symbol_edge so callers can register edge-aligned pulses.
module uart_baud_cnt #(
  parameter int BIT_TIME = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  output logic symbol_edge,
  output logic symbol_pre
);

  localparam int CNT_W = (BIT_TIME < 2) ? 1 : $clog2(BIT_TIME);

  if (BIT_TIME < 2) begin : g_bit_time_check
    $error("uart_baud_cnt: BIT_TIME must be >= 2");
  end

  logic [CNT_W-1:0] cnt;

  assign symbol_edge = en && (cnt == CNT_W'(BIT_TIME - 1));
  assign symbol_pre  = en && (cnt == CNT_W'(BIT_TIME - 2));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (!en || symbol_edge) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with valid/ready byte intake and a registered line output.
//
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | start bit (0) on the line
//   DATA  | data bits, LSB first, from shift[0]
//   STOP  | stop bit (1); may accept the next byte on its last cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      serial_out,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int BIT_TIME = calc_bit_time(CLOCK_FREQ, BAUD_RATE);

  uart_state_e               state;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      symbol_edge;
  logic                      symbol_pre;
  logic                      handshake;

  assign busy      = (state != IDLE);
  assign tx_ready  = (state == IDLE) || ((state == STOP) && symbol_edge);
  assign handshake = tx_valid && tx_ready;

  uart_baud_cnt #(
    .BIT_TIME(BIT_TIME)
  ) u_baud_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (busy),
    .symbol_edge(symbol_edge),
    .symbol_pre (symbol_pre)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_idx    <= 3'd0;
      shift      <= '0;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      // Set one cycle early so the pulse lands on the stop bit's final cycle.
      tx_done <= (state == STOP) && symbol_pre;
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          bit_idx    <= 3'd0;
          if (handshake) begin
            shift      <= tx_data;
            serial_out <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (symbol_edge) begin
            bit_idx    <= 3'd0;
            serial_out <= shift[0];
            state      <= DATA;
          end
        end
        DATA: begin
          if (symbol_edge) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              serial_out <= shift[1];
            end
          end
        end
        STOP: begin
          if (symbol_edge) begin
            if (handshake) begin
              shift      <= tx_data;
              serial_out <= 1'b0;
              state      <= START;
            end else begin
              serial_out <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: begin
          serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
